// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU operation codes, NZCV flag layout and exec-unit FSM states.
package cpu_pkg;

    // Operation codes produced by the ALU decoder.
    typedef enum logic [2:0] {
        ALU_AND  = 3'b000,
        ALU_MUL  = 3'b001,
        ALU_ADD  = 3'b010,
        ALU_MOV  = 3'b011,
        ALU_LSR  = 3'b100,
        ALU_LSL  = 3'b101,
        ALU_SUB  = 3'b110,
        ALU_RSVD = 3'b111
    } alu_ctrl_t;

    // Bit positions within the 4-bit {N,Z,C,V} flag vector.
    localparam int unsigned FLAGS_W = 4;
    localparam int unsigned FLAG_N  = 3;
    localparam int unsigned FLAG_Z  = 2;
    localparam int unsigned FLAG_C  = 1;
    localparam int unsigned FLAG_V  = 0;

    // Execution unit control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } exec_state_t;

endpackage

// File: rtl/alu_seq_mult.sv
// Iterative shift-add multiplier returning the low WIDTH bits of an unsigned product.
// The final partial-product add is folded into product_c so the owner can register the
// result on the same edge that would perform the last iteration.
module alu_seq_mult #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             run,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             done,
    output logic [WIDTH-1:0] product_c
);

    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [SHW-1:0]   count_q;
    logic             done_q;
    logic [WIDTH-1:0] addend_c;

    // Partial product contributed by the current multiplier LSB.
    always_comb begin
        addend_c  = mplier_q[0] ? mcand_q : '0;
        product_c = acc_q + addend_c;
    end

    // Load operands on start, then run WIDTH-1 registered iterations; the last one is product_c.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            done_q   <= 1'b0;
        end else if (start) begin
            mcand_q  <= multiplicand;
            mplier_q <= multiplier;
            acc_q    <= '0;
            count_q  <= '0;
            done_q   <= 1'b0;
        end else if (run && !done_q) begin
            acc_q    <= product_c;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            count_q  <= count_q + SHW'(1);
            if (count_q == SHW'(WIDTH - 2)) begin
                done_q <= 1'b1;
            end
        end
    end

    assign done = done_q;

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: valid/ready request in, registered Result/NZCV out.
// Single-cycle ops complete on the acceptance edge; MUL uses the iterative core.
module alu_exec_unit
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         ALUControl,
    input  logic [WIDTH-1:0]   SrcA,
    input  logic [WIDTH-1:0]   SrcB,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   Result,
    output logic [FLAGS_W-1:0] Flags
);

    localparam int unsigned MSB = WIDTH - 1;

    exec_state_t        state_q;
    exec_state_t        state_d;
    alu_ctrl_t          op_c;
    logic               accept_c;
    logic               load_c;
    logic               mul_start_c;
    logic               mul_done;
    logic [WIDTH-1:0]   mul_product_c;
    logic [WIDTH:0]     add_c;
    logic [WIDTH:0]     sub_c;
    logic [WIDTH-1:0]   alu_res_c;
    logic [FLAGS_W-1:0] alu_flags_c;
    logic [WIDTH-1:0]   res_d;
    logic [FLAGS_W-1:0] flags_d;

    assign op_c     = alu_ctrl_t'(ALUControl);
    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept_c = in_valid && in_ready;

    // Single-cycle datapath: result and NZCV for every op except MUL.
    always_comb begin
        add_c       = {1'b0, SrcA} + {1'b0, SrcB};
        sub_c       = {1'b0, SrcA} + {1'b0, ~SrcB} + (WIDTH + 1)'(1);
        alu_res_c   = '0;
        alu_flags_c = '0;
        unique case (op_c)
            ALU_AND: alu_res_c = SrcA & SrcB;
            ALU_ADD: begin
                alu_res_c           = add_c[MSB:0];
                alu_flags_c[FLAG_C] = add_c[WIDTH];
                alu_flags_c[FLAG_V] = (SrcA[MSB] == SrcB[MSB]) && (add_c[MSB] != SrcA[MSB]);
            end
            ALU_MOV: alu_res_c = SrcB;
            ALU_LSR: alu_res_c = SrcB >> SrcA[SHW-1:0];
            ALU_LSL: alu_res_c = SrcB << SrcA[SHW-1:0];
            ALU_SUB: begin
                // Carry out of A + ~B + 1 is the inverted borrow.
                alu_res_c           = sub_c[MSB:0];
                alu_flags_c[FLAG_C] = sub_c[WIDTH];
                alu_flags_c[FLAG_V] = (SrcA[MSB] != SrcB[MSB]) && (sub_c[MSB] != SrcA[MSB]);
            end
            default: alu_res_c = '0;
        endcase
        alu_flags_c[FLAG_N] = alu_res_c[MSB];
        alu_flags_c[FLAG_Z] = (alu_res_c == '0);
        if (op_c == ALU_RSVD) begin
            alu_flags_c = '0;
        end
    end

    // Next-state logic and result-register load selection.
    always_comb begin
        state_d     = state_q;
        load_c      = 1'b0;
        mul_start_c = 1'b0;
        res_d       = alu_res_c;
        flags_d     = alu_flags_c;
        unique case (state_q)
            IDLE, DONE: begin
                if (accept_c) begin
                    if (op_c == ALU_MUL) begin
                        mul_start_c = 1'b1;
                        state_d     = MUL;
                    end else begin
                        load_c  = 1'b1;
                        state_d = DONE;
                    end
                end else if ((state_q == DONE) && out_ready) begin
                    state_d = IDLE;
                end
            end
            MUL: begin
                if (mul_done) begin
                    load_c          = 1'b1;
                    res_d           = mul_product_c;
                    flags_d         = '0;
                    flags_d[FLAG_N] = mul_product_c[MSB];
                    flags_d[FLAG_Z] = (mul_product_c == '0);
                    state_d         = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, out_valid and held Result/Flags registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            out_valid <= 1'b0;
            Result    <= '0;
            Flags     <= '0;
        end else begin
            state_q   <= state_d;
            out_valid <= (state_d == DONE);
            if (load_c) begin
                Result <= res_d;
                Flags  <= flags_d;
            end
        end
    end

    alu_seq_mult #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_mult (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (mul_start_c),
        .run          (state_q == MUL),
        .multiplicand (SrcA),
        .multiplier   (SrcB),
        .done         (mul_done),
        .product_c    (mul_product_c)
    );

endmodule
